// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame sequencer: state encoding, default
// transform parameters and the bin-index bit reversal.
package fft_ctrl_pkg;

    localparam int FFT_N_DEF     = 1024;
    localparam int FFT_NLOG2_DEF = 10;
    localparam int STAGES_DEF    = 5;
    localparam int PIPE_LAT_DEF  = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } fft_state_e;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Handshake and chain-control bundle between the sample source / result sink
// (master) and the FFT frame sequencer (slave).
interface fft_ctrl_if
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_NLOG2 = FFT_NLOG2_DEF
);
    logic                 start_i;
    logic                 in_valid_i;
    logic                 busy_o;
    logic                 ready_o;
    logic [FFT_NLOG2-1:0] cnt_o;
    logic                 zero_sel_o;
    logic                 pipe_rst_o;
    logic                 out_valid_o;
    logic [FFT_NLOG2-1:0] out_idx_o;
    logic                 out_last_o;
    logic                 err_o;

    modport master (
        output start_i, in_valid_i,
        input  busy_o, ready_o, cnt_o, zero_sel_o, pipe_rst_o,
        input  out_valid_o, out_idx_o, out_last_o, err_o
    );

    modport slave (
        input  start_i, in_valid_i,
        output busy_o, ready_o, cnt_o, zero_sel_o, pipe_rst_o,
        output out_valid_o, out_idx_o, out_last_o, err_o
    );
endinterface

// File: rtl/fft_ctrl_outseq.sv
// Output sequencer: waits out the chain latency after sample 0, then tags N
// consecutive chain outputs with valid, bit-reversed bin index and last.
module fft_ctrl_outseq
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_N     = FFT_N_DEF,
    parameter int FFT_NLOG2 = FFT_NLOG2_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 clr_i,
    output logic                 out_valid_o,
    output logic [FFT_NLOG2-1:0] out_idx_o,
    output logic                 out_last_o
);
    localparam int                   DLY_W  = $clog2(PIPE_LAT + FFT_N);
    localparam logic [FFT_NLOG2-1:0] K_LAST = FFT_NLOG2'(FFT_N - 1);

    logic                 pend;
    logic [DLY_W-1:0]     dly;
    logic [FFT_NLOG2-1:0] k;
    logic [FFT_NLOG2-1:0] k_nx;

    assign k_nx = k + FFT_NLOG2'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            pend        <= 1'b0;
            dly         <= '0;
            k           <= '0;
            out_valid_o <= 1'b0;
            out_idx_o   <= '0;
            out_last_o  <= 1'b0;
        end else begin
            if (out_valid_o) begin
                if (k == K_LAST) begin
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                    out_idx_o   <= '0;
                    k           <= '0;
                end else begin
                    k          <= k_nx;
                    out_idx_o  <= FFT_NLOG2'(bitrev(32'(k_nx), FFT_NLOG2));
                    out_last_o <= (k_nx == K_LAST);
                end
            end
            // dly==1 here means the first bin reaches the chain output next cycle
            if (load_i) begin
                pend <= 1'b1;
                dly  <= DLY_W'(PIPE_LAT - 1);
            end else if (pend) begin
                if (dly == DLY_W'(1)) begin
                    pend        <= 1'b0;
                    out_valid_o <= 1'b1;
                    k           <= '0;
                    out_idx_o   <= '0;
                    out_last_o  <= (K_LAST == '0);
                end
                dly <= dly - DLY_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_ctrl.sv
// Frame sequencer for the radix-2^2 SDF butterfly chain: loads one contiguous
// frame, drains the pipeline with zeros and aborts on a mid-frame input stall.
module fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_N     = FFT_N_DEF,
    parameter int FFT_NLOG2 = FFT_NLOG2_DEF,
    parameter int STAGES    = STAGES_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    fft_ctrl_if.slave  bus
);
    localparam int                   DLY_W    = $clog2(PIPE_LAT + FFT_N);
    localparam logic [FFT_NLOG2-1:0] CNT_LAST = FFT_NLOG2'(FFT_N - 1);

    if (STAGES * 2 != FFT_NLOG2 || FFT_N != (1 << FFT_NLOG2) || PIPE_LAT < 2) begin : g_param_chk
        $error("fft_ctrl: inconsistent FFT_N / FFT_NLOG2 / STAGES / PIPE_LAT");
    end

    fft_state_e           state;
    logic [FFT_NLOG2-1:0] cnt;
    logic [DLY_W-1:0]     drain_cnt;
    logic                 accept0;
    logic                 abort;

    assign accept0   = (state == ST_ARMED) && bus.in_valid_i;
    assign abort     = (state == ST_LOAD) && !bus.in_valid_i;
    assign bus.cnt_o = cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            drain_cnt      <= '0;
            bus.busy_o     <= 1'b0;
            bus.ready_o    <= 1'b0;
            bus.zero_sel_o <= 1'b1;
            bus.pipe_rst_o <= 1'b1;
            bus.err_o      <= 1'b0;
        end else begin
            bus.pipe_rst_o <= 1'b0;
            bus.err_o      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state          <= ST_ARMED;
                        bus.busy_o     <= 1'b1;
                        bus.ready_o    <= 1'b1;
                        bus.zero_sel_o <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (bus.in_valid_i) begin
                        state <= ST_LOAD;
                        cnt   <= cnt + FFT_NLOG2'(1);
                    end
                end
                ST_LOAD: begin
                    if (!bus.in_valid_i) begin
                        state          <= ST_IDLE;
                        cnt            <= '0;
                        bus.busy_o     <= 1'b0;
                        bus.ready_o    <= 1'b0;
                        bus.zero_sel_o <= 1'b1;
                        bus.pipe_rst_o <= 1'b1;
                        bus.err_o      <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state          <= ST_DRAIN;
                        cnt            <= '0;
                        drain_cnt      <= DLY_W'(PIPE_LAT - 1);
                        bus.ready_o    <= 1'b0;
                        bus.zero_sel_o <= 1'b1;
                    end else begin
                        cnt <= cnt + FFT_NLOG2'(1);
                    end
                end
                ST_DRAIN: begin
                    // the chain's stage counters must keep turning while zeros flush it
                    if (drain_cnt == '0) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        bus.busy_o <= 1'b0;
                    end else begin
                        cnt       <= cnt + FFT_NLOG2'(1);
                        drain_cnt <= drain_cnt - DLY_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fft_ctrl_outseq #(
        .FFT_N     (FFT_N),
        .FFT_NLOG2 (FFT_NLOG2),
        .PIPE_LAT  (PIPE_LAT)
    ) u_outseq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept0),
        .clr_i       (abort),
        .out_valid_o (bus.out_valid_o),
        .out_idx_o   (bus.out_idx_o),
        .out_last_o  (bus.out_last_o)
    );

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl at N=16: directed frames, stall abort,
// ignored starts, mid-drain reset and an impulse through a bench-side chain model.
module tb_fft_ctrl;
    localparam int N  = 16;
    localparam int NL = 4;
    localparam int ST = 2;
    localparam int PL = 17;

    typedef struct {
        int cyc;
        int idx;
        int last;
        bit chk_bin;
        int bin;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic signed [15:0] data_in = '0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   xs[N];
    int   brev_tab[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int   cos_q[N]    = '{1024, 946, 724, 392, 0, -392, -724, -946,
                          -1024, -946, -724, -392, 0, 392, 724, 946};

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    fft_ctrl_if #(.FFT_NLOG2(NL)) bus();

    fft_ctrl #(.FFT_N(N), .FFT_NLOG2(NL), .STAGES(ST), .PIPE_LAT(PL)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Chain model: samples the mux output into the frame buffer at the stage-0 index.
    always @(posedge clk_i) begin
        if (bus.in_valid_i && !bus.zero_sel_o) xs[bus.cnt_o] <= int'(data_in);
    end

    function automatic int bin_re(input logic [NL-1:0] k);
        int s;
        s = 0;
        for (int n = 0; n < N; n++) s += xs[n] * cos_q[(int'(k) * n) % N];
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (bus.out_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_cycle", cyc, mon_e.cyc);
                check("out_idx", int'(bus.out_idx_o), mon_e.idx);
                check("out_last", int'(bus.out_last_o), mon_e.last);
                if (mon_e.chk_bin) check("bin_value", bin_re(bus.out_idx_o), mon_e.bin);
            end
        end else begin
            check("last_without_valid", int'(bus.out_last_o), 0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("missing_out_valid", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},      int'(bus.busy_o),      0);
        check({tag, "_ready"},     int'(bus.ready_o),     0);
        check({tag, "_cnt"},       int'(bus.cnt_o),       0);
        check({tag, "_zero_sel"},  int'(bus.zero_sel_o),  1);
        check({tag, "_pipe_rst"},  int'(bus.pipe_rst_o),  1);
        check({tag, "_out_valid"}, int'(bus.out_valid_o), 0);
        check({tag, "_out_idx"},   int'(bus.out_idx_o),   0);
        check({tag, "_out_last"},  int'(bus.out_last_o),  0);
        check({tag, "_err"},       int'(bus.err_o),       0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_busy", int'(bus.busy_o), 0);
        end
    endtask

    task automatic start_frame(input bit with_sample);
        bus.start_i    = 1'b1;
        bus.in_valid_i = with_sample;
        data_in        = with_sample ? 16'sd7 : 16'sd0;
        tick();
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        data_in        = '0;
        check("armed_busy",  int'(bus.busy_o),  1);
        check("armed_ready", int'(bus.ready_o), 1);
    endtask

    task automatic feed(input int nsamp, input int npush, input bit impulse, input bit poke);
        int acc;
        for (int i = 0; i < nsamp; i++) begin
            check("load_cnt",      int'(bus.cnt_o),      i);
            check("load_zero_sel", int'(bus.zero_sel_o), 0);
            check("load_ready",    int'(bus.ready_o),    1);
            if (i == 0) begin
                acc = cyc;
                for (int j = 0; j < npush; j++)
                    exp_q.push_back('{cyc: acc + PL + j, idx: brev_tab[j], last: int'(j == N - 1),
                                      chk_bin: impulse, bin: 5 * 1024});
            end
            bus.in_valid_i = 1'b1;
            data_in        = (impulse && i == 0) ? 16'sd5 : 16'sd0;
            bus.start_i    = poke && (i == 8);
            tick();
        end
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
        data_in        = '0;
    endtask

    task automatic drain(input int rst_at, input bit garbage, input bit poke);
        for (int d = 1; d <= PL; d++) begin
            check("drain_busy",     int'(bus.busy_o),     1);
            check("drain_zero_sel", int'(bus.zero_sel_o), 1);
            check("drain_ready",    int'(bus.ready_o),    0);
            check("drain_cnt",      int'(bus.cnt_o),      (d - 1) % N);
            if (d == rst_at) begin
                rst_i          = 1'b1;
                bus.in_valid_i = 1'b0;
                tick();
                check_reset_vals("midrst");
                rst_i = 1'b0;
                tick();
                check("midrst_pipe_rst_rel", int'(bus.pipe_rst_o), 0);
                return;
            end
            bus.in_valid_i = garbage;
            data_in        = garbage ? 16'sd7 : 16'sd0;
            bus.start_i    = poke && (d == 5);
            tick();
        end
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
        data_in        = '0;
        check("end_busy",     int'(bus.busy_o),     0);
        check("end_cnt",      int'(bus.cnt_o),      0);
        check("end_zero_sel", int'(bus.zero_sel_o), 1);
        check("end_ready",    int'(bus.ready_o),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b0;

        // reset for 3 cycles, then release
        repeat (3) tick();
        check_reset_vals("reset");
        rst_i = 1'b0;
        tick();
        check("release_pipe_rst", int'(bus.pipe_rst_o), 0);
        check("release_busy",     int'(bus.busy_o),     0);
        check("release_zero_sel", int'(bus.zero_sel_o), 1);

        // normal frame
        start_frame(1'b0);
        feed(N, N, 1'b0, 1'b0);
        drain(0, 1'b0, 1'b0);
        idle(20);

        // stall at sample 5 aborts the frame
        start_frame(1'b0);
        feed(5, 0, 1'b0, 1'b0);
        tick();
        check("abort_err",      int'(bus.err_o),      1);
        check("abort_pipe_rst", int'(bus.pipe_rst_o), 1);
        check("abort_busy",     int'(bus.busy_o),     0);
        check("abort_ready",    int'(bus.ready_o),    0);
        check("abort_cnt",      int'(bus.cnt_o),      0);
        check("abort_zero_sel", int'(bus.zero_sel_o), 1);
        tick();
        check("abort_err_pulse",      int'(bus.err_o),      0);
        check("abort_pipe_rst_pulse", int'(bus.pipe_rst_o), 0);
        idle(40);

        // start pulses during LOAD and DRAIN are ignored, then a second frame
        start_frame(1'b0);
        feed(N, N, 1'b0, 1'b1);
        drain(0, 1'b1, 1'b1);
        idle(5);
        start_frame(1'b0);
        feed(N, N, 1'b0, 1'b0);
        drain(0, 1'b0, 1'b0);
        idle(20);

        // reset in the third drain cycle: two bins already out, the rest discarded
        start_frame(1'b0);
        feed(N, 2, 1'b0, 1'b0);
        drain(3, 1'b0, 1'b0);
        idle(30);

        // impulse frame; start with a sample in IDLE, junk samples during drain
        start_frame(1'b1);
        feed(N, N, 1'b1, 1'b0);
        drain(0, 1'b1, 1'b0);
        idle(20);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
